lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: memory request FSM with byte-lane formatting, timeout and optional misalignment trap (LSU_MISALIGN_TRAP_EN)
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_err,
    output logic        o_misalign
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [2:0]      funct3_q;
    logic [1:0]      lane_q;
    logic [CW-1:0]   cnt;
    logic            timeout;
    logic            misalign_req;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata;
    logic [31:0]     ld_fmt;

    // The cycle that would bring the counter to TIMEOUT_CYCLES abandons the access
    assign timeout = ((32'(cnt) + 32'd1) >= TIMEOUT_CYCLES);

`ifdef LSU_MISALIGN_TRAP_EN
    // Halves need addr[0]=0, words (funct3[1]=1 covers 010 and 011) need addr[1:0]=00
    assign misalign_req = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                          (i_funct3[1] && (i_addr[1:0] != 2'b00));
`else
    assign misalign_req = 1'b0;
`endif

    // Store lane placement: replicate the datum so the byte enables pick the lane
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << i_addr[1:0];
                st_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = i_store_data;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the captured funct3 and lane
    always_comb begin
        logic [31:0] sh;
        sh     = i_mem_rdata;
        ld_fmt = i_mem_rdata;
        case (funct3_q[1:0])
            2'b00: begin
                sh     = i_mem_rdata >> {lane_q, 3'b000};
                ld_fmt = funct3_q[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh     = i_mem_rdata >> {lane_q[1], 4'b0000};
                ld_fmt = funct3_q[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: begin
                sh     = i_mem_rdata;
                ld_fmt = i_mem_rdata;
            end
        endcase
    end

    // Request FSM; every output is a flop so the memory side sees glitch-free signals
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            o_req_ready <= 1'b1;
            o_mem_valid <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 32'd0;
            o_mem_be    <= 4'b0000;
            o_done      <= 1'b0;
            o_load_data <= 32'd0;
            o_err       <= 1'b0;
            o_misalign  <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            cnt         <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_err      <= 1'b0;
                    o_misalign <= 1'b0;
                    if (i_req_valid) begin
                        o_req_ready <= 1'b0;
                        funct3_q    <= i_funct3;
                        lane_q      <= i_addr[1:0];
                        cnt         <= '0;
                        if (misalign_req) begin
                            state      <= S_DONE;
                            o_done     <= 1'b1;
                            o_misalign <= 1'b1;
                        end else begin
                            state       <= S_REQ;
                            o_mem_valid <= 1'b1;
                            o_mem_we    <= i_is_store;
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_be    <= i_is_store ? st_be : 4'b1111;
                            o_mem_wdata <= i_is_store ? st_wdata : 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    cnt <= cnt + CW'(1);
                    if (i_mem_ready) begin
                        o_mem_valid <= 1'b0;
                        if (o_mem_we) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (timeout) begin
                        o_mem_valid <= 1'b0;
                        state       <= S_DONE;
                        o_done      <= 1'b1;
                        o_err       <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (i_mem_rvalid) begin
                        o_load_data <= ld_fmt;
                        state       <= S_DONE;
                        o_done      <= 1'b1;
                    end else if (timeout) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                        o_err  <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
